// File: rtl/diffeq_pkg.sv
// Shared types and constants for the differentiator host sequencer.
// Holds the FSM state encoding, operand slot indices and default widths.
package diffeq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      GAP,
      RUN,
      FINISH
   } state_e;

   localparam int OPND_W    = 4;
   localparam int DEF_OUT_W = 16;

   localparam logic [1:0] IDX_X  = 2'd0;
   localparam logic [1:0] IDX_DX = 2'd1;
   localparam logic [1:0] IDX_A  = 2'd2;
   localparam logic [1:0] IDX_U  = 2'd3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/diffeq_phase_timer.sv
// Loadable down-counter; tc_o flags zero so a phase loaded with N-1 lasts N cycles.
// Shared by the setup/hold/gap phases and the run timeout.
module diffeq_phase_timer #(
   parameter int W = 10
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/diffeq_host_seq.sv
// Host sequencer: loads x/dx/a/u into the differentiator with timed strobes,
// raises ready, then captures the result on a d_valid rising edge or times out.
module diffeq_host_seq
   import diffeq_pkg::*;
#(
   parameter int SETUP_CYCLES = 1,
   parameter int HOLD_CYCLES  = 4,
   parameter int GAP_CYCLES   = 1,
   parameter int TIMEOUT      = 1023,
   parameter int OUT_W        = DEF_OUT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OPND_W-1:0] x_in,
   input  logic [OPND_W-1:0] dx_in,
   input  logic [OPND_W-1:0] a_in,
   input  logic [OPND_W-1:0] u_in,
   output logic              busy,
   output logic              done,
   output logic [OUT_W-1:0]  result,
   output logic              timeout_err,
   output logic              s1,
   output logic              s2,
   output logic              s3,
   output logic              s4,
   output logic [OPND_W-1:0] d_in,
   output logic              ready,
   input  logic [OUT_W-1:0]  d_out,
   input  logic              d_valid
);

   localparam int MAX_CNT = max_int(max_int(SETUP_CYCLES, HOLD_CYCLES),
                                    max_int(GAP_CYCLES, TIMEOUT));
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_RUN   = CNT_W'(TIMEOUT - 1);

   state_e                       state_q, state_d;
   logic [1:0]                   idx_q, idx_d;
   logic [3:0][OPND_W-1:0]       opnd_q, opnd_d;
   logic [OUT_W-1:0]             result_q, result_d;
   logic                         terr_q, terr_d;
   logic                         dvld_q;
   logic                         tmr_load, tmr_en, tmr_tc;
   logic [CNT_W-1:0]             tmr_val;
   logic                         capture;

   diffeq_phase_timer #(.W(CNT_W)) u_timer (
      .clk_i      (clk),
      .rst_ni     (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .tc_o       (tmr_tc)
   );

   // Only a fresh rising edge counts; a valid already high on RUN entry is ignored.
   assign capture = (state_q == RUN) && d_valid && !dvld_q;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      terr_d   = terr_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               opnd_d[IDX_X]  = x_in;
               opnd_d[IDX_DX] = dx_in;
               opnd_d[IDX_A]  = a_in;
               opnd_d[IDX_U]  = u_in;
               idx_d    = IDX_X;
               terr_d   = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = LD_SETUP;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            if (tmr_tc) begin
               tmr_load = 1'b1;
               tmr_val  = LD_HOLD;
               state_d  = STROBE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         STROBE: begin
            if (tmr_tc) begin
               tmr_load = 1'b1;
               tmr_val  = LD_GAP;
               state_d  = GAP;
            end else begin
               tmr_en = 1'b1;
            end
         end
         GAP: begin
            if (!tmr_tc) begin
               tmr_en = 1'b1;
            end else if (idx_q == IDX_U) begin
               tmr_load = 1'b1;
               tmr_val  = LD_RUN;
               state_d  = RUN;
            end else begin
               idx_d    = idx_q + 2'd1;
               tmr_load = 1'b1;
               tmr_val  = LD_SETUP;
               state_d  = SETUP;
            end
         end
         RUN: begin
            // Capture takes priority over a timeout landing in the same cycle.
            if (capture) begin
               result_d = d_out;
               state_d  = FINISH;
            end else if (tmr_tc) begin
               terr_d  = 1'b1;
               state_d = FINISH;
            end else begin
               tmr_en = 1'b1;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         terr_q   <= 1'b0;
         dvld_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         terr_q   <= terr_d;
         dvld_q   <= d_valid;
      end
   end

   always_comb begin
      busy          = state_q inside {SETUP, STROBE, GAP, RUN};
      ready         = (state_q == RUN);
      done          = (state_q == FINISH);
      d_in          = (state_q inside {SETUP, STROBE, GAP}) ? opnd_q[idx_q] : '0;
      {s4, s3, s2, s1} = (state_q == STROBE) ? (4'b0001 << idx_q) : 4'b0000;
      result        = result_q;
      timeout_err   = terr_q;
   end

endmodule

// File: doc/diffeq_host_seq.md
Name: diffeq_host_seq

Overview:
- Host-side sequencer that drives the differentiator's load/compute interface.
- Latches four 4-bit operands (x, dx, a, u) on a start pulse.
- Presents each operand on d_in with its select strobe (s1..s4) using programmable setup/hold timing, then raises ready.
- Waits for valid, captures the 16-bit result and reports done or timeout to the controlling logic.

Parameters:
SETUP_CYCLES, 1, cycles d_in is stable before the strobe rises (>=1)
HOLD_CYCLES, 4, cycles each strobe s1..s4 is held high (>=1)
GAP_CYCLES, 1, cycles with strobe low between operands (>=1)
TIMEOUT, 1023, max RUN cycles waiting for valid rising edge (>=2)
OUT_W, 16, result width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; ignored while busy
x_in  in  4  operand x
dx_in  in  4  operand dx
a_in  in  4  operand a
u_in  in  4  operand u
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle completion pulse (success or timeout)
result  out  OUT_W  captured output; holds until next capture
timeout_err  out  1  sticky; set with done on timeout, cleared on next accepted start
s1  out  1  load strobe for x
s2  out  1  load strobe for dx
s3  out  1  load strobe for a
s4  out  1  load strobe for u
d_in  out  4  operand bus to differentiator
ready  out  1  compute request to differentiator
d_out  in  OUT_W  differentiator result
d_valid  in  1  differentiator result valid

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=IDLE, counters 0, operand regs 0. Strobes and ready drop immediately, mid-operation included. No done pulse.
- FSM states: IDLE, SETUP, STROBE, GAP, RUN, FINISH.
- IDLE: start=1 latches x/dx/a/u and sets idx=0, clears timeout_err, moves to SETUP; busy=1 next cycle.
- d_in = operand[idx] (0:x, 1:dx, 2:a, 3:u) in SETUP/STROBE/GAP. It changes only on entry to SETUP and is 0 in IDLE/RUN/FINISH.
- SETUP: SETUP_CYCLES cycles, all strobes 0, then STROBE.
- STROBE: s[idx+1]=1 for exactly HOLD_CYCLES cycles. At most one strobe is ever high. Then GAP.
- GAP: GAP_CYCLES cycles, strobes 0. If idx<3: idx++, go to SETUP. Else go to RUN.
- Load phase length is 4*(SETUP_CYCLES+HOLD_CYCLES+GAP_CYCLES) cycles; with defaults ready rises 24 cycles after the start edge.
- RUN: ready=1, cycle counter increments each cycle.
  - Capture only on a d_valid rising edge (registered d_valid_q=0, d_valid=1); a valid already high at RUN entry is not accepted.
  - On capture: result<=d_out, go to FINISH.
  - If the counter reaches TIMEOUT with no capture: timeout_err<=1, result unchanged, go to FINISH.
  - Capture and timeout in the same cycle: capture wins, timeout_err stays 0.
- FINISH: one cycle with ready=0, done=1, busy=0, then IDLE.
- start during FINISH is ignored. start in IDLE is accepted on the cycle after FINISH.
- start during busy: ignored, operands unchanged.
- d_valid outside RUN: ignored.

Decomposition:
- Package diffeq_pkg holds:
  - state enum (IDLE, SETUP, STROBE, GAP, RUN, FINISH)
  - operand index constants (IDX_X=0, IDX_DX=1, IDX_A=2, IDX_U=3)
  - OPND_W=4, default OUT_W=16
- One sub-module, diffeq_phase_timer: loadable down-counter with a terminal-count flag. It is reused for the SETUP/HOLD/GAP durations and the RUN timeout.

Test Plan:
- Reset pulse mid-STROBE (s2 high) -> s1..s4, ready, d_in, busy drop within the reset assertion; after release the FSM is IDLE and result=0.
- start with x=3, dx=1, a=7, u=9, defaults -> expected waveform:
  - d_in sequence 3,1,7,9
  - s1..s4 each high exactly 4 cycles, in order, never overlapping
  - ready high at start+24
- Continuing that run, a model raises d_valid 40 cycles after ready with d_out=16'd1234 -> result=1234, one-cycle done, timeout_err=0, ready low in the done cycle.
- d_valid held high before RUN and never toggled, TIMEOUT=50 -> done at RUN entry+50 with timeout_err=1, result unchanged.
- start re-pulsed during STROBE with different operands -> ignored; original operands complete the load.
- Back-to-back: start the cycle after done with new operands -> accepted, timeout_err cleared, new sequence correct.
